fwd_hazard_unit: RTL and testbench

Parametrised successor to the EX-stage forwarding unit. It resolves RAW hazards for NUM_SRC source operands of the instruction leaving ID. Forward-select codes are registered one cycle ahead, so EX sees a clean select; the data mux reads live MEM/WB results. It adds load-use hazard detection with a LOAD_LAT-cycle stall FSM, optional hardwired zero register, and a saturating stall-cycle counter. It sits between the ID/EX pipeline register and the EX operand muxes.

---
 rtl/fwd_hazard_unit.sv | 132 +++++++++++++
 tb/tb_fwd_hazard_unit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding and load-use hazard unit.
// Forward-select codes are registered one cycle ahead; operand data is muxed from live MEM/WB results.
module fwd_hazard_unit #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned REG_AW      = 4,
  parameter int unsigned NUM_SRC     = 2,
  parameter int unsigned LOAD_LAT    = 1,
  parameter int unsigned ZERO_REG_EN = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        id_valid,
  input  logic [NUM_SRC*REG_AW-1:0]   id_rs,
  input  logic [REG_AW-1:0]           ex_reg_dst,
  input  logic                        ex_wr,
  input  logic                        ex_is_load,
  input  logic [REG_AW-1:0]           mem_reg_dst,
  input  logic                        mem_wr,
  input  logic [DATA_W-1:0]           mem_reg_data,
  input  logic [DATA_W-1:0]           wb_reg_data,
  input  logic                        cnt_clr,
  output logic [NUM_SRC*DATA_W-1:0]   fwd_data,
  output logic [NUM_SRC-1:0]          fwd_sel,
  output logic                        stall,
  output logic [CNT_W-1:0]            stall_cnt
);

  localparam int unsigned LAT_W = (LOAD_LAT > 0) ? $clog2(LOAD_LAT + 1) : 1;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(LOAD_LAT - 1);
  localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  localparam logic [1:0] CODE_NONE = 2'd0;
  localparam logic [1:0] CODE_MEM  = 2'd1;
  localparam logic [1:0] CODE_WB   = 2'd2;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

  logic [NUM_SRC-1:0] src_valid;
  logic [NUM_SRC-1:0] ex_match;
  logic [NUM_SRC-1:0] mem_match;
  logic               load_hz;

  logic [0:0]         state_q, state_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic               stall_c;
  logic [CNT_W-1:0]   cnt_q;

  // Per-source match and registered forward code; the youngest producer (EX) wins.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    logic [REG_AW-1:0] rs;
    logic [1:0]        code_q;

    assign rs           = id_rs[g*REG_AW +: REG_AW];
    assign src_valid[g] = id_valid & ((ZERO_REG_EN == 0) | (rs != '0));
    assign ex_match[g]  = src_valid[g] & ex_wr  & (ex_reg_dst  == rs);
    assign mem_match[g] = src_valid[g] & mem_wr & (mem_reg_dst == rs);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        code_q <= CODE_NONE;
      end else if (ex_match[g]) begin
        code_q <= CODE_MEM;
      end else if (mem_match[g]) begin
        code_q <= CODE_WB;
      end else begin
        code_q <= CODE_NONE;
      end
    end

    assign fwd_sel[g] = (code_q != CODE_NONE);
    assign fwd_data[g*DATA_W +: DATA_W] = (code_q == CODE_MEM) ? mem_reg_data :
                                          (code_q == CODE_WB)  ? wb_reg_data  : '0;
  end

  assign load_hz = (LOAD_LAT != 0) & ex_is_load & ex_wr & (|ex_match);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
    end
  end

  // Stall sequencer: the detecting cycle is the first stall cycle, STALL covers the rest.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    stall_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stall_c = load_hz;
        if (load_hz && (LOAD_LAT > 1)) begin
          state_d = ST_STALL;
          lat_d   = LAT_INIT;
        end
      end
      ST_STALL: begin
        stall_c = 1'b1;
        lat_d   = lat_q - LAT_ONE;
        if (lat_q == LAT_ONE) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        lat_d   = '0;
      end
    endcase
  end

  assign stall = stall_c & rst_n;

  // Saturating stall-cycle counter; clear beats increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (stall_c && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed vectors plus random stimulus against a
// stall-budget reference model, across four parameter sets sharing one input bus.
module tb_fwd_hazard_unit;

  typedef struct {
    logic        rst_n;
    logic        id_valid;
    logic [3:0]  rs0, rs1, ex_dst, mem_dst;
    logic        ex_wr, ex_ld, mem_wr, clr;
    logic [31:0] mem_d, wb_d;
  } in_t;

  typedef struct {
    in_t         in;
    logic [1:0]  sel;
    logic [31:0] d0, d1;
    logic        stall;
    logic [15:0] cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [7:0]  id_rs = '0;
  logic [3:0]  ex_reg_dst = '0, mem_reg_dst = '0;
  logic        ex_wr = 1'b0, ex_is_load = 1'b0, mem_wr = 1'b0, cnt_clr = 1'b0;
  logic [31:0] mem_reg_data = '0, wb_reg_data = '0;

  logic [63:0] fd [4];
  logic [1:0]  fs [4];
  logic        st [4];
  logic [15:0] sc0, sc1, sc3;
  logic [1:0]  sc2;
  logic [15:0] sc [4];

  // Instance parameters, mirrored for the reference model.
  int ll [4] = '{1, 3, 1, 0};
  int ze [4] = '{1, 1, 1, 0};
  int cw [4] = '{16, 16, 2, 16};

  int m_code [4][2];
  int m_rem  [4];
  int m_cnt  [4];

  int nchk = 0;
  int npass = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.LOAD_LAT(1)) u_i0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs),
    .ex_reg_dst(ex_reg_dst), .ex_wr(ex_wr), .ex_is_load(ex_is_load),
    .mem_reg_dst(mem_reg_dst), .mem_wr(mem_wr), .mem_reg_data(mem_reg_data),
    .wb_reg_data(wb_reg_data), .cnt_clr(cnt_clr),
    .fwd_data(fd[0]), .fwd_sel(fs[0]), .stall(st[0]), .stall_cnt(sc0));

  fwd_hazard_unit #(.LOAD_LAT(3)) u_i1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs),
    .ex_reg_dst(ex_reg_dst), .ex_wr(ex_wr), .ex_is_load(ex_is_load),
    .mem_reg_dst(mem_reg_dst), .mem_wr(mem_wr), .mem_reg_data(mem_reg_data),
    .wb_reg_data(wb_reg_data), .cnt_clr(cnt_clr),
    .fwd_data(fd[1]), .fwd_sel(fs[1]), .stall(st[1]), .stall_cnt(sc1));

  fwd_hazard_unit #(.LOAD_LAT(1), .CNT_W(2)) u_i2 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs),
    .ex_reg_dst(ex_reg_dst), .ex_wr(ex_wr), .ex_is_load(ex_is_load),
    .mem_reg_dst(mem_reg_dst), .mem_wr(mem_wr), .mem_reg_data(mem_reg_data),
    .wb_reg_data(wb_reg_data), .cnt_clr(cnt_clr),
    .fwd_data(fd[2]), .fwd_sel(fs[2]), .stall(st[2]), .stall_cnt(sc2));

  fwd_hazard_unit #(.LOAD_LAT(0), .ZERO_REG_EN(0)) u_i3 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs),
    .ex_reg_dst(ex_reg_dst), .ex_wr(ex_wr), .ex_is_load(ex_is_load),
    .mem_reg_dst(mem_reg_dst), .mem_wr(mem_wr), .mem_reg_data(mem_reg_data),
    .wb_reg_data(wb_reg_data), .cnt_clr(cnt_clr),
    .fwd_data(fd[3]), .fwd_sel(fs[3]), .stall(st[3]), .stall_cnt(sc3));

  assign sc[0] = sc0;
  assign sc[1] = sc1;
  assign sc[2] = {14'd0, sc2};
  assign sc[3] = sc3;

  function automatic in_t mk(input logic r, input logic v, input logic [3:0] r0, input logic [3:0] r1,
                             input logic [3:0] exd, input logic exw, input logic exl,
                             input logic [3:0] memd, input logic memw,
                             input logic [31:0] md, input logic [31:0] wd, input logic c);
    in_t x;
    x.rst_n = r; x.id_valid = v; x.rs0 = r0; x.rs1 = r1;
    x.ex_dst = exd; x.ex_wr = exw; x.ex_ld = exl;
    x.mem_dst = memd; x.mem_wr = memw; x.mem_d = md; x.wb_d = wd; x.clr = c;
    return x;
  endfunction

  function automatic vec_t mv(input in_t x, input logic [1:0] s, input logic [31:0] a,
                              input logic [31:0] b, input logic stl, input logic [15:0] c);
    vec_t v;
    v.in = x; v.sel = s; v.d0 = a; v.d1 = b; v.stall = stl; v.cnt = c;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [3:0] src_of(input in_t x, input int s);
    return (s == 0) ? x.rs0 : x.rs1;
  endfunction

  function automatic bit m_valid(input int k, input in_t x, input int s);
    return x.id_valid && (ze[k] == 0 || src_of(x, s) != 4'd0);
  endfunction

  function automatic bit m_loadhz(input int k, input in_t x);
    bit hit = 0;
    for (int s = 0; s < 2; s++)
      if (m_valid(k, x, s) && src_of(x, s) == x.ex_dst) hit = 1;
    return ll[k] > 0 && x.ex_ld && x.ex_wr && hit;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_code[k][0] = 0; m_code[k][1] = 0; m_rem[k] = 0; m_cnt[k] = 0;
    end
  endtask

  // Drive one cycle, compare every instance against the model, then advance the model.
  task automatic apply(input in_t x);
    logic [63:0] ed;
    logic [1:0]  es;
    bit          estl;
    @(negedge clk);
    rst_n = x.rst_n; id_valid = x.id_valid; id_rs = {x.rs1, x.rs0};
    ex_reg_dst = x.ex_dst; ex_wr = x.ex_wr; ex_is_load = x.ex_ld;
    mem_reg_dst = x.mem_dst; mem_wr = x.mem_wr;
    mem_reg_data = x.mem_d; wb_reg_data = x.wb_d; cnt_clr = x.clr;
    #1;
    if (!x.rst_n) model_reset();
    for (int k = 0; k < 4; k++) begin
      ed = '0; es = '0;
      for (int s = 0; s < 2; s++) begin
        es[s] = (m_code[k][s] != 0);
        ed[s*32 +: 32] = (m_code[k][s] == 1) ? x.mem_d : (m_code[k][s] == 2) ? x.wb_d : 32'd0;
      end
      estl = x.rst_n && (m_rem[k] > 0 || m_loadhz(k, x));
      check($sformatf("model_i%0d_sel", k), 64'(fs[k]), 64'(es));
      check($sformatf("model_i%0d_data", k), fd[k], ed);
      check($sformatf("model_i%0d_stall", k), 64'(st[k]), 64'(estl));
      check($sformatf("model_i%0d_cnt", k), 64'(sc[k]), 64'(m_cnt[k]));
      if (x.rst_n) begin
        for (int s = 0; s < 2; s++) begin
          if (m_valid(k, x, s) && x.ex_wr && src_of(x, s) == x.ex_dst) m_code[k][s] = 1;
          else if (m_valid(k, x, s) && x.mem_wr && src_of(x, s) == x.mem_dst) m_code[k][s] = 2;
          else m_code[k][s] = 0;
        end
        if (m_rem[k] > 0) m_rem[k]--;
        else if (m_loadhz(k, x)) m_rem[k] = ll[k] - 1;
        if (x.clr) m_cnt[k] = 0;
        else if (estl && m_cnt[k] < (1 << cw[k]) - 1) m_cnt[k]++;
      end
    end
  endtask

  task automatic dchk(input string nm, input int k, input logic stl, input logic [15:0] c);
    check({nm, "_stall"}, 64'(st[k]), 64'(stl));
    check({nm, "_cnt"}, 64'(sc[k]), 64'(c));
  endtask

  vec_t tbl [12];
  in_t  q, hz, held_mem, held;

  initial begin
    model_reset();
    tbl[0]  = mv(mk(0,0,0,0,0,0,0,0,0,0,0,0), 2'b00, 0, 0, 0, 0);
    tbl[1]  = mv(mk(1,0,0,0,0,0,0,0,0,0,0,0), 2'b00, 0, 0, 0, 0);
    tbl[2]  = mv(mk(1,1,5,3,5,1,0,0,0,0,0,0), 2'b00, 0, 0, 0, 0);
    tbl[3]  = mv(mk(1,0,0,0,0,0,0,0,0,32'hAAAA_0001,32'h1234_5678,0), 2'b01, 32'hAAAA_0001, 0, 0, 0);
    tbl[4]  = mv(mk(1,1,0,7,7,1,0,7,1,0,0,0), 2'b00, 0, 0, 0, 0);
    tbl[5]  = mv(mk(1,0,0,0,0,0,0,0,0,32'h1111_0000,32'h2222_0000,0), 2'b10, 0, 32'h1111_0000, 0, 0);
    tbl[6]  = mv(mk(1,1,0,0,0,1,0,0,1,0,0,0), 2'b00, 0, 0, 0, 0);
    tbl[7]  = mv(mk(1,0,0,0,0,0,0,0,0,32'h7777_0000,32'h8888_0000,0), 2'b00, 0, 0, 0, 0);
    tbl[8]  = mv(mk(1,1,4,9,4,1,1,0,0,0,0,0), 2'b00, 0, 0, 1, 0);
    tbl[9]  = mv(mk(1,1,4,9,0,0,0,4,1,32'h3333_0000,32'h4444_0000,0), 2'b01, 32'h3333_0000, 0, 0, 1);
    tbl[10] = mv(mk(1,0,0,0,0,0,0,0,0,32'h6666_0000,32'h5555_0000,0), 2'b01, 32'h5555_0000, 0, 0, 1);
    tbl[11] = mv(mk(1,0,0,0,0,0,0,0,0,0,0,0), 2'b00, 0, 0, 0, 1);

    for (int i = 0; i < 12; i++) begin
      apply(tbl[i].in);
      check($sformatf("vec%0d_sel", i), 64'(fs[0]), 64'(tbl[i].sel));
      check($sformatf("vec%0d_data", i), fd[0], {tbl[i].d1, tbl[i].d0});
      dchk($sformatf("vec%0d", i), 0, tbl[i].stall, tbl[i].cnt);
    end

    q        = mk(1,0,0,0,0,0,0,0,0,0,0,0);
    hz       = mk(1,1,4,9,4,1,1,0,0,32'hCAFE_0001,32'hBEEF_0002,0);
    held_mem = mk(1,1,4,9,0,0,0,4,1,32'hCAFE_0003,32'hBEEF_0004,0);
    held     = mk(1,1,4,9,0,0,0,0,0,32'hCAFE_0005,32'hBEEF_0006,0);

    // Three-cycle load-use stall, then a clear landing mid-stall.
    q.clr = 1; apply(q); q.clr = 0;
    apply(hz);       dchk("lat3_c1", 1, 1, 0);
    apply(held_mem); dchk("lat3_c2", 1, 1, 1);
    apply(held);     dchk("lat3_c3", 1, 1, 2);
    apply(held);     dchk("lat3_done", 1, 0, 3);
    apply(hz);       dchk("clr_c1", 1, 1, 3);
    held_mem.clr = 1; apply(held_mem); held_mem.clr = 0;
    dchk("clr_c2", 1, 1, 4);
    apply(held);     dchk("clr_c3", 1, 1, 0);
    apply(held);     dchk("clr_done", 1, 0, 1);

    // Reset asserted inside the second stall cycle.
    apply(q);
    apply(hz);       dchk("rst_c1", 1, 1, 1);
    apply(held_mem); dchk("rst_c2", 1, 1, 2);
    check("rst_c2_sel", 64'(fs[1]), 64'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    dchk("rst_async", 1, 0, 0);
    check("rst_async_sel", 64'(fs[1]), 64'd0);
    q.rst_n = 0; apply(q); q.rst_n = 1;
    apply(q);        dchk("rst_rel1", 1, 0, 0);
    apply(held);     dchk("rst_rel2", 1, 0, 0);

    // Back-to-back single-cycle stalls saturate a 2-bit counter.
    q.clr = 1; apply(q); q.clr = 0;
    for (int i = 0; i < 5; i++) begin
      apply(hz);
      dchk($sformatf("sat_c%0d", i), 2, 1, 16'((i > 3) ? 3 : i));
    end
    apply(mk(1,0,4,4,4,1,1,4,1,0,0,0));
    dchk("inval_i2", 2, 0, 3);
    check("inval_i0_stall", 64'(st[0]), 64'd0);
    apply(q);
    check("inval_sel", 64'(fs[2]), 64'd0);

    for (int i = 0; i < 3000; i++) begin
      in_t r;
      r.rst_n    = ($urandom_range(0, 199) != 0);
      r.id_valid = ($urandom_range(0, 3) != 0);
      r.rs0      = 4'($urandom_range(0, 3));
      r.rs1      = 4'($urandom_range(0, 3));
      r.ex_dst   = 4'($urandom_range(0, 3));
      r.mem_dst  = 4'($urandom_range(0, 3));
      r.ex_wr    = 1'($urandom_range(0, 1));
      r.ex_ld    = ($urandom_range(0, 2) == 0);
      r.mem_wr   = 1'($urandom_range(0, 1));
      r.clr      = ($urandom_range(0, 19) == 0);
      r.mem_d    = $urandom;
      r.wb_d     = $urandom;
      apply(r);
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
